// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared state, lamp and timing definitions for the Semaforo lamp path
// Purpose: phase/state encoding (0-6), lamp bundle ordering {red, yellow, green},
//          default timing constants and the state-to-lamp decode.
// Ports:   none (package).
package semaforo_pkg;

  localparam int DEF_MIN_GREEN_CYCLES = 4;
  localparam int DEF_YELLOW_CYCLES    = 2;
  localparam int DEF_ALL_RED_CYCLES   = 1;
  localparam int DEF_CNT_W            = 8;

  // The numeric value of each state is also the externally visible phase.
  typedef enum logic [2:0] {
    ST_INIT_RED  = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_RED_TO_LO = 3'd3,
    ST_LO_GREEN  = 3'd4,
    ST_LO_YELLOW = 3'd5,
    ST_RED_TO_NS = 3'd6
  } state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  // Returns {ns_lamp, lo_lamp}. Anything unrecognised decodes to all-red.
  function automatic logic [5:0] lamps_of(input state_t s);
    lamp_t ns_l;
    lamp_t lo_l;
    ns_l = LAMP_RED;
    lo_l = LAMP_RED;
    case (s)
      ST_NS_GREEN:  ns_l = LAMP_GREEN;
      ST_NS_YELLOW: ns_l = LAMP_YELLOW;
      ST_LO_GREEN:  lo_l = LAMP_GREEN;
      ST_LO_YELLOW: lo_l = LAMP_YELLOW;
      default:      ;
    endcase
    return {ns_l, lo_l};
  endfunction

endpackage

// File: rtl/semaforo_phase_timer.sv
// rtl/semaforo_phase_timer.sv - per-phase cycle counter with saturating done compare
// Purpose: counts cycles spent in the current phase; clears on a phase change,
//          otherwise increments and saturates at i_limit-1.
// Ports:   i_clock, i_reset_n (async active-low), i_clear (phase changes this edge),
//          i_limit (cycle limit of the current phase), o_done (count reached i_limit-1).
module semaforo_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == (i_limit - CNT_W'(1)));
  assign o_done = w_done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (!w_done) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/semaforo_lamp_driver.sv
// rtl/semaforo_lamp_driver.sv - turns NS/LO grant requests into the six safe lamp outputs
// Purpose: sequences green -> yellow -> all-red -> other green with a minimum green,
//          fixed yellow and fixed clearance; the two approaches are never both non-red.
// Ports:   clock, reset_n (async active-low); NS, LO (grant requests);
//          ns_red/ns_yellow/ns_green, lo_red/lo_yellow/lo_green (lamps);
//          phase (current state), green_start (first green cycle pulse),
//          req_conflict (sticky: NS and LO sampled high together).
module semaforo_lamp_driver
  import semaforo_pkg::*;
#(
  parameter int MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
  parameter int YELLOW_CYCLES    = DEF_YELLOW_CYCLES,
  parameter int ALL_RED_CYCLES   = DEF_ALL_RED_CYCLES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       NS,
  input  logic       LO,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       lo_red,
  output logic       lo_yellow,
  output logic       lo_green,
  output logic [2:0] phase,
  output logic       green_start,
  output logic       req_conflict
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_limit;
  logic             w_done;
  logic             w_ns_req;
  logic             w_lo_req;
  logic             w_change;
  logic [5:0]       r_lamps;
  logic             r_green_start;
  logic             r_req_conflict;

  // Both high is as meaningless as both low: neither counts as a request.
  assign w_ns_req = NS & ~LO;
  assign w_lo_req = LO & ~NS;
  assign w_change = (w_next != r_state);

  always_comb begin
    w_limit = CNT_W'(ALL_RED_CYCLES);
    case (r_state)
      ST_NS_GREEN,  ST_LO_GREEN:  w_limit = CNT_W'(MIN_GREEN_CYCLES);
      ST_NS_YELLOW, ST_LO_YELLOW: w_limit = CNT_W'(YELLOW_CYCLES);
      default:                    w_limit = CNT_W'(ALL_RED_CYCLES);
    endcase
  end

  semaforo_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_clear   (w_change),
    .i_limit   (w_limit),
    .o_done    (w_done)
  );

  // Yellow and clearance phases advance on time alone; once yellow starts
  // the changeover is committed regardless of what the requests do.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT_RED: begin
        if (w_done && w_ns_req)      w_next = ST_NS_GREEN;
        else if (w_done && w_lo_req) w_next = ST_LO_GREEN;
      end
      ST_NS_GREEN:  if (w_done && w_lo_req) w_next = ST_NS_YELLOW;
      ST_NS_YELLOW: if (w_done)             w_next = ST_RED_TO_LO;
      ST_RED_TO_LO: if (w_done)             w_next = ST_LO_GREEN;
      ST_LO_GREEN:  if (w_done && w_ns_req) w_next = ST_LO_YELLOW;
      ST_LO_YELLOW: if (w_done)             w_next = ST_RED_TO_NS;
      ST_RED_TO_NS: if (w_done)             w_next = ST_NS_GREEN;
      default:                              w_next = ST_INIT_RED;
    endcase
  end

  // Outputs are decoded from the next state so lamps move on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_INIT_RED;
      r_lamps        <= lamps_of(ST_INIT_RED);
      r_green_start  <= 1'b0;
      r_req_conflict <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_lamps        <= lamps_of(w_next);
      r_green_start  <= w_change && ((w_next == ST_NS_GREEN) || (w_next == ST_LO_GREEN));
      r_req_conflict <= r_req_conflict | (NS & LO);
    end
  end

  assign {ns_red, ns_yellow, ns_green, lo_red, lo_yellow, lo_green} = r_lamps;
  assign phase        = r_state;
  assign green_start  = r_green_start;
  assign req_conflict = r_req_conflict;

endmodule

// File: doc/semaforo_lamp_driver.md
Name: semaforo_lamp_driver

Overview:
- Downstream end of the Semaforo direction-request interface: consumes the registered NS/LO grant requests and drives the six physical lamps (red/yellow/green per approach).
- Enforces a minimum green, a fixed yellow and an all-red clearance on every changeover.
- Guarantees that the two approaches are never simultaneously non-red.
- Sits between the Semaforo controller and the lamp output pins.

Parameters:
- MIN_GREEN_CYCLES, 4: minimum clock cycles a green phase is held (>=1).
- YELLOW_CYCLES, 2: exact clock cycles of each yellow phase (>=1).
- ALL_RED_CYCLES, 1: exact all-red clearance cycles; also the minimum length of INIT_RED (>=1).
- CNT_W, 8: phase counter width; every cycle parameter must be < 2**CNT_W.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- NS  in  1  request for north-south green (from Semaforo).
- LO  in  1  request for east-west green (from Semaforo).
- ns_red, ns_yellow, ns_green  out  1 each  north-south lamps.
- lo_red, lo_yellow, lo_green  out  1 each  east-west lamps.
- phase  out  3  current state encoding.
- green_start  out  1  one-cycle pulse on the first cycle of any green.
- req_conflict  out  1  sticky flag: NS and LO were high on the same sampled edge.

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT_RED, cnt=0, phase=0.
  - ns_red=lo_red=1; all yellow and green lamps=0.
  - green_start=0, req_conflict=0.
  - Takes effect immediately, including mid-green or mid-yellow.
- Valid request: exactly one of NS/LO high. NS=LO=0 or NS=LO=1 is "no valid request".
- All outputs are registered and decoded from the next state, so lamps change on the same edge as the state.
- cnt clears to 0 on every state change, otherwise increments by 1 and saturates at the state's limit minus 1.
- States and phase encoding:
  - 0 INIT_RED: both red.
    - When cnt==ALL_RED_CYCLES-1: NS valid -> NS_GREEN; LO valid -> LO_GREEN; otherwise stay (cnt saturated).
  - 1 NS_GREEN: ns_green=1, lo_red=1.
    - When cnt==MIN_GREEN_CYCLES-1 and LO valid -> NS_YELLOW; otherwise hold.
    - An NS-only request or an invalid request holds green indefinitely.
  - 2 NS_YELLOW: ns_yellow=1, lo_red=1.
    - When cnt==YELLOW_CYCLES-1 -> RED_TO_LO, unconditionally; request changes are ignored.
  - 3 RED_TO_LO: both red.
    - When cnt==ALL_RED_CYCLES-1 -> LO_GREEN, unconditionally (the change is committed).
  - 4 LO_GREEN, 5 LO_YELLOW, 6 RED_TO_NS: mirror images of states 1-3, with NS and LO swapped.
  - Phase 7 is unused; if reached, it goes to INIT_RED on the next edge.
- green_start: 1 for exactly the first cycle of NS_GREEN or LO_GREEN, 0 otherwise.
- req_conflict: set on any edge that samples NS=1 and LO=1; cleared only by reset.
- Safety invariant, every cycle: exactly one lamp per approach is lit, and at least one approach is red.
- Phase durations: green >= MIN_GREEN_CYCLES; yellow == YELLOW_CYCLES; clearance == ALL_RED_CYCLES.

Decomposition:
- Shared package (semaforo_pkg):
  - state/phase localparams 0-6.
  - lamp bundle ordering {red, yellow, green}.
  - default timing constants, shared with the Semaforo controller bench.
- Natural sub-module: semaforo_phase_timer. Holds the counter clear/increment/saturate logic and the "done" compare against a limit input. Instantiated once; the limit is muxed from the current state.

Test Plan:
- Reset, then NS=1, LO=0 from release -> INIT_RED for 1 cycle. Edge 1: NS_GREEN, green_start=1 for that cycle only, lo_red=1.
- Continuing: switch to LO=1, NS=0 at edge 1 -> ns_green holds through edge 4. Edges 5-6: ns_yellow. Edge 7: both red. Edge 8: lo_green=1 with green_start pulse.
- LO_GREEN active with NS=LO=0 for 20 cycles -> lo_green stays 1 and phase stays 4. Then NS=1 -> LO_YELLOW on the next edge once the minimum green has elapsed.
- NS=LO=1 for one edge during NS_GREEN -> req_conflict=1 and stays 1. Lamps unchanged; no transition occurs.
- Drop reset_n mid NS_YELLOW (asynchronous, between edges) -> ns_red=lo_red=1 immediately and phase=0. After release, the sequence restarts from INIT_RED.
- Request flips back to NS during RED_TO_LO -> LO_GREEN is still entered. A checker asserts the safety invariant on every cycle of every test.
